// File: rtl/circuit7_div_sched.sv
//==============================================================================
// Module   : circuit7_div_sched
// Purpose  : Sequencing controller for the Circuit7 datapath. Computes
//            z = (a mod b == zero) ? a/b : c/d using one shared iterative
//            restoring divider (one quotient bit per cycle). The divider runs
//            an a/b pass (quotient e, remainder g) and then a c/d pass
//            (quotient f). Start/done handshake; z is registered.
// Options  : CIRCUIT7_SKIP_DIV_EN - when defined, the c/d pass is skipped
//            whenever g equals zero. This gives data-dependent latency.
//            Undefined (default): constant-time, both passes always run.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module circuit7_div_sched #(
  parameter int DATAWIDTH = 64
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] c,
  input  logic [DATAWIDTH-1:0] d,
  input  logic [DATAWIDTH-1:0] zero,
  output logic                 busy,
  output logic                 done,
  output logic                 div0,
  output logic [DATAWIDTH-1:0] z
);

  // The step counter covers 0..DATAWIDTH-1 and is one bit wider than needed,
  // so it can never wrap inside a pass.
  localparam int                 CNT_W     = $clog2(DATAWIDTH) + 1;
  localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(DATAWIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV_AB = 2'd1,
    DIV_CD = 2'd2,
    SELECT = 2'd3
  } state_t;

  state_t               state_q;

  // Shared divider: quo_q shifts the dividend out at the top while quotient
  // bits enter at the bottom; rem_q holds the partial remainder.
  logic [DATAWIDTH-1:0] rem_q;
  logic [DATAWIDTH-1:0] quo_q;
  logic [DATAWIDTH-1:0] dvsr_q;
  logic [CNT_W-1:0]     cnt_q;

  // Operands still needed after the a/b pass has been loaded.
  logic [DATAWIDTH-1:0] c_q;
  logic [DATAWIDTH-1:0] d_q;
  logic [DATAWIDTH-1:0] zero_q;
  logic                 b_zero_q;
  logic                 cd_ran_q;

  // Pass results.
  logic [DATAWIDTH-1:0] e_q;
  logic [DATAWIDTH-1:0] f_q;
  logic [DATAWIDTH-1:0] g_q;

  // Registered outputs.
  logic [DATAWIDTH-1:0] z_q;
  logic                 done_q;
  logic                 div0_q;

  // Next values of one restoring step.
  logic [DATAWIDTH:0]   rem_shift_d;
  logic [DATAWIDTH-1:0] trial_d;
  logic [DATAWIDTH-1:0] rem_d;
  logic [DATAWIDTH-1:0] quo_d;
  logic                 fits_d;
  logic                 last_d;

  // One restoring division step: shift in the next dividend bit, trial
  // subtract, and keep the difference only if it did not go negative. A zero
  // divisor always "fits", yielding all-ones quotient and remainder = dividend.
  always_comb begin
    rem_shift_d = {rem_q, quo_q[DATAWIDTH-1]};
    fits_d      = (rem_shift_d >= {1'b0, dvsr_q});
    // When the divisor fits, the difference is below the divisor, so the
    // low DATAWIDTH bits of the shifted remainder are enough.
    trial_d     = rem_shift_d[DATAWIDTH-1:0] - dvsr_q;
    rem_d       = fits_d ? trial_d : rem_shift_d[DATAWIDTH-1:0];
    quo_d       = {quo_q[DATAWIDTH-2:0], fits_d};
    last_d      = (cnt_q == LAST_STEP);
  end

  // Controller FSM, divider datapath and registered outputs.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      c_q      <= '0;
      d_q      <= '0;
      zero_q   <= '0;
      b_zero_q <= 1'b0;
      cd_ran_q <= 1'b0;
      e_q      <= '0;
      f_q      <= '0;
      g_q      <= '0;
      z_q      <= '0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            quo_q    <= a;
            rem_q    <= '0;
            dvsr_q   <= b;
            cnt_q    <= '0;
            c_q      <= c;
            d_q      <= d;
            zero_q   <= zero;
            b_zero_q <= (b == '0);
            cd_ran_q <= 1'b0;
            state_q  <= DIV_AB;
          end
        end

        DIV_AB: begin
          if (last_d) begin
            e_q    <= quo_d;
            g_q    <= rem_d;
            // Reload the divider with c/d straight away; harmless if the
            // pass ends up being skipped.
            quo_q  <= c_q;
            rem_q  <= '0;
            dvsr_q <= d_q;
            cnt_q  <= '0;
`ifdef CIRCUIT7_SKIP_DIV_EN
            if (rem_d == zero_q) begin
              state_q <= SELECT;
            end else begin
              cd_ran_q <= 1'b1;
              state_q  <= DIV_CD;
            end
`else
            cd_ran_q <= 1'b1;
            state_q  <= DIV_CD;
`endif
          end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DIV_CD: begin
          if (last_d) begin
            f_q     <= quo_d;
            state_q <= SELECT;
          end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        SELECT: begin
          z_q     <= (g_q == zero_q) ? e_q : f_q;
          div0_q  <= b_zero_q | ((d_q == '0) & cd_ran_q);
          done_q  <= 1'b1;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign div0 = div0_q;
  assign z    = z_q;

endmodule

`default_nettype wire

// File: tb/tb_circuit7_div_sched.sv
//==============================================================================
// Module   : tb_circuit7_div_sched
// Purpose  : Self-checking bench for circuit7_div_sched with a plain-arithmetic
//            reference model, directed corner cases and random operands.
// Options  : CIRCUIT7_SKIP_DIV_EN - must match the DUT build.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_circuit7_div_sched;

  localparam int             W    = 64;
  localparam logic [W-1:0]   ONES = '1;
  localparam int             TMO  = 400;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0, c = '0, d = '0, zero = '0;
  logic         busy, done, div0;
  logic [W-1:0] z;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  circuit7_div_sched #(.DATAWIDTH(W)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .zero  (zero),
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .z     (z)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Reference: z = (a mod b == zero) ? a/b : c/d, with x/0 = all ones, x%0 = x.
  function automatic void model(input logic [W-1:0] ia, ib, ic, id, iz,
                                output logic [W-1:0] ez, output logic ed0, output int elat);
    logic [W-1:0] e, g, f;
    bit cd_ran;
    if (ib == 0) begin e = ONES; g = ia; end
    else begin e = ia / ib; g = ia % ib; end
    f = (id == 0) ? ONES : ic / id;
    cd_ran = 1'b1;
`ifdef CIRCUIT7_SKIP_DIV_EN
    if (g == iz) cd_ran = 1'b0;
`endif
    ez   = (g == iz) ? e : f;
    ed0  = (ib == 0) || ((id == 0) && cd_ran);
    elat = cd_ran ? 2 * W + 1 : W + 1;
  endfunction

  // Called just after the accept edge; counts edges until done is seen.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < TMO) begin
      @(posedge Clk); #1;
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] ia, ib, ic, id, iz);
    logic [W-1:0] ez;
    logic ed0;
    int el, lat, bcnt;
    model(ia, ib, ic, id, iz, ez, ed0, el);
    @(negedge Clk);
    a = ia; b = ib; c = ic; d = id; zero = iz; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    // Operands must have been latched; scramble them during the operation.
    a = rand64(); b = rand64(); c = rand64(); d = rand64(); zero = rand64();
    wait_done(lat, bcnt);
    check_eq({tag, "_latency"}, W'(lat), W'(el));
    check_eq({tag, "_busycycles"}, W'(bcnt), W'(el));
    check_eq({tag, "_z"}, z, ez);
    check_eq({tag, "_div0"}, W'(div0), W'(ed0));
    @(posedge Clk); #1;
    check_eq({tag, "_donepulse"}, W'(done), W'(0));
  endtask

  initial begin
    logic [W-1:0] ra, rb, rc, rd, rz;
    logic [W-1:0] ez1, ez2;
    logic ed1, ed2;
    int el1, el2, lat, bcnt, ndone;

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    check_eq("rst_busy", W'(busy), W'(0));
    check_eq("rst_done", W'(done), W'(0));
    check_eq("rst_div0", W'(div0), W'(0));
    check_eq("rst_z", z, '0);
    @(negedge Clk); Rst = 1'b1;

    // Directed cases
    do_op("sel_e", 64'd100, 64'd7, 64'd50, 64'd5, 64'd2);
    do_op("sel_f", 64'd100, 64'd7, 64'd50, 64'd5, 64'd0);
    do_op("b_zero", 64'd5, 64'd0, 64'd9, 64'd3, 64'd5);
    do_op("d_zero", 64'd9, 64'd3, 64'd1, 64'd0, 64'd1);
    do_op("max_z0", ONES, 64'd1, ONES, ONES, 64'd0);
    do_op("max_z1", ONES, 64'd1, ONES, ONES, 64'd1);

    // Random operands
    for (int i = 0; i < 16; i++) begin
      ra = rand64();
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = 64'($urandom_range(1, 1000));
        2:       rb = 64'($urandom());
        default: rb = rand64();
      endcase
      rc = rand64();
      case ($urandom_range(0, 3))
        0:       rd = '0;
        1:       rd = 64'($urandom_range(1, 1000));
        default: rd = rand64();
      endcase
      if ($urandom_range(0, 1) == 1) rz = (rb == 0) ? ra : ra % rb;
      else                           rz = 64'($urandom_range(0, 7));
      do_op($sformatf("rnd%0d", i), ra, rb, rc, rd, rz);
    end

    // Reset in the middle of an operation
    @(negedge Clk);
    a = 64'd1000; b = 64'd10; c = 64'd77; d = 64'd7; zero = 64'd0; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (39) @(posedge Clk);
    #1 Rst = 1'b0;
    @(posedge Clk); #1;
    check_eq("midrst_busy", W'(busy), W'(0));
    check_eq("midrst_done", W'(done), W'(0));
    check_eq("midrst_z", z, '0);
    check_eq("midrst_div0", W'(div0), W'(0));
    @(negedge Clk); Rst = 1'b1;
    ndone = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge Clk); #1;
      if (done) ndone++;
    end
    check_eq("midrst_nodone", W'(ndone), W'(0));
    do_op("after_rst", 64'd1000, 64'd10, 64'd77, 64'd7, 64'd0);

    // start held high: back-to-back operations, operands changed at edge 10
    ra = rand64(); rb = 64'($urandom_range(1, 5000)); rc = rand64(); rd = 64'($urandom_range(1, 99));
    rz = ra % rb;
    model(ra, rb, rc, rd, rz, ez1, ed1, el1);
    model(64'd100, 64'd7, 64'd50, 64'd5, 64'd0, ez2, ed2, el2);
    @(negedge Clk);
    a = ra; b = rb; c = rc; d = rd; zero = rz; start = 1'b1;
    @(posedge Clk); #1;
    lat = 0;
    while (!done && lat < TMO) begin
      @(posedge Clk); #1;
      lat++;
      if (lat == 10) begin
        a = 64'd100; b = 64'd7; c = 64'd50; d = 64'd5; zero = 64'd0;
      end
    end
    check_eq("held1_latency", W'(lat), W'(el1));
    check_eq("held1_z", z, ez1);
    check_eq("held1_div0", W'(div0), W'(ed1));
    // Still in the done cycle with start high: the next edge accepts op 2.
    lat = 0;
    bcnt = 0;
    do begin
      @(posedge Clk); #1;
      lat++;
      if (busy) bcnt++;
    end while (!done && lat < TMO);
    start = 1'b0;
    check_eq("held2_period", W'(lat), W'(el2 + 1));
    check_eq("held2_busycycles", W'(bcnt), W'(el2));
    check_eq("held2_z", z, ez2);
    check_eq("held2_div0", W'(div0), W'(ed2));
    @(posedge Clk); #1;
    check_eq("held2_idle", W'(busy), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
